// File: rtl/mycpu_pkg.sv
// Shared definitions for the data request path: access size encodings,
// controller states and byte-lane helpers for stores.
package mycpu_pkg;

  localparam int CNT_W = 2;

  localparam logic [1:0] SZ_BYTE  = 2'd0;
  localparam logic [1:0] SZ_HALF  = 2'd1;
  localparam logic [1:0] SZ_WORD  = 2'd2;
  localparam logic [1:0] SZ_WORD3 = 2'd3;

  typedef enum logic {
    S_IDLE = 1'b0,
    S_REQ  = 1'b1
  } state_e;

  // Size 3 is an alias of word; the bus only ever sees 0..2.
  function automatic logic [1:0] norm_size(input logic [1:0] size);
    return (size == SZ_WORD3) ? SZ_WORD : size;
  endfunction

  function automatic logic [3:0] mk_wstrb(input logic [1:0] size, input logic [1:0] addr_lo);
    case (size)
      SZ_BYTE: return 4'b0001 << addr_lo;
      SZ_HALF: return 4'b0011 << {addr_lo[1], 1'b0};
      default: return 4'b1111;
    endcase
  endfunction

  function automatic logic [31:0] mk_wdata(input logic [1:0] size, input logic [31:0] wdata);
    case (size)
      SZ_BYTE: return {4{wdata[7:0]}};
      SZ_HALF: return {2{wdata[15:0]}};
      default: return wdata;
    endcase
  endfunction

  function automatic logic is_misaligned(input logic [1:0] size, input logic [1:0] addr_lo);
    case (size)
      SZ_BYTE: return 1'b0;
      SZ_HALF: return addr_lo[0];
      default: return addr_lo != 2'b00;
    endcase
  endfunction

endpackage

// File: rtl/data_req_cnt.sv
// Tracks bus transactions in flight and how many of the oldest ones belong to
// a cancelled pipeline and must have their responses swallowed.
module data_req_cnt
  import mycpu_pkg::*;
#(
  parameter int OUTSTANDING_MAX = 2
) (
  input  logic clk,
  input  logic resetn,
  input  logic i_issue,
  input  logic i_data_ok,
  input  logic i_flush,
  output logic o_has_room,
  output logic o_fwd
);

  logic [CNT_W-1:0] r_out;
  logic [CNT_W-1:0] r_disc;
  logic [CNT_W-1:0] w_out_next;
  logic [CNT_W-1:0] w_disc_next;
  logic             w_dok;
  logic             w_dok_disc;

  // A data_ok with nothing in flight is stray and must not underflow.
  assign w_dok      = i_data_ok && (r_out != '0);
  assign w_dok_disc = w_dok && (r_disc != '0);

  assign w_out_next = r_out + CNT_W'(i_issue) - CNT_W'(w_dok);
  assign o_has_room = w_out_next < CNT_W'(OUTSTANDING_MAX);

  // Everything still in flight after this cycle predates the flush.
  assign w_disc_next = i_flush ? w_out_next : (r_disc - CNT_W'(w_dok_disc));
  assign o_fwd       = w_dok && !w_dok_disc && !i_flush;

  always_ff @(posedge clk) begin
    if (!resetn) begin
      r_out  <= '0;
      r_disc <= '0;
    end else begin
      r_out  <= w_out_next;
      r_disc <= w_disc_next;
    end
  end

endmodule

// File: rtl/data_req_ctrl.sv
// Execute-stage data access controller driving an SRAM-like bus.
// Define DATA_REQ_ALE_CHK_EN to trap misaligned accesses instead of issuing them.
module data_req_ctrl
  import mycpu_pkg::*;
#(
  parameter int OUTSTANDING_MAX = 2
) (
  input  logic        clk,
  input  logic        resetn,
  input  logic        es_req_valid,
  input  logic        es_req_wr,
  input  logic [1:0]  es_req_size,
  input  logic [31:0] es_req_addr,
  input  logic [31:0] es_req_wdata,
  output logic        es_req_ready,
  input  logic        flush,
  output logic        data_sram_req,
  output logic        data_sram_wr,
  output logic [1:0]  data_sram_size,
  output logic [31:0] data_sram_addr,
  output logic [3:0]  data_sram_wstrb,
  output logic [31:0] data_sram_wdata,
  input  logic        data_sram_addr_ok,
  input  logic        data_sram_data_ok,
  input  logic [31:0] data_sram_rdata,
  output logic        ms_resp_valid,
  output logic [31:0] ms_resp_rdata,
  output logic        ms_ale
);

  state_e      r_state;
  state_e      w_state_next;
  logic        r_wr;
  logic [1:0]  r_size;
  logic [31:0] r_addr;
  logic [3:0]  r_wstrb;
  logic [31:0] r_wdata;
  logic        r_resp_valid;
  logic [31:0] r_resp_rdata;

  logic w_issue;
  logic w_slot_free;
  logic w_has_room;
  logic w_fwd;
  logic w_accept;
  logic w_misalign;
  logic w_launch;

  data_req_cnt #(
    .OUTSTANDING_MAX(OUTSTANDING_MAX)
  ) u_cnt (
    .clk       (clk),
    .resetn    (resetn),
    .i_issue   (w_issue),
    .i_data_ok (data_sram_data_ok),
    .i_flush   (flush),
    .o_has_room(w_has_room),
    .o_fwd     (w_fwd)
  );

  // A handshake under flush still reaches the bus, so it is counted as issued.
  assign w_issue      = (r_state == S_REQ) && data_sram_addr_ok;
  assign w_slot_free  = (r_state == S_IDLE) || w_issue;
  assign es_req_ready = resetn && w_slot_free && w_has_room && !flush;
  assign w_accept     = es_req_valid && es_req_ready;

`ifdef DATA_REQ_ALE_CHK_EN
  logic r_ale;

  assign w_misalign = is_misaligned(es_req_size, es_req_addr[1:0]);
  assign ms_ale     = r_ale;

  always_ff @(posedge clk) begin
    if (!resetn) begin
      r_ale <= 1'b0;
    end else begin
      r_ale <= w_accept && w_misalign;
    end
  end
`else
  assign w_misalign = 1'b0;
  assign ms_ale     = 1'b0;
`endif

  assign w_launch = w_accept && !w_misalign;

  always_comb begin
    w_state_next = r_state;
    if (flush) begin
      w_state_next = S_IDLE;
    end else if (w_launch) begin
      w_state_next = S_REQ;
    end else if (w_issue) begin
      w_state_next = S_IDLE;
    end
  end

  always_ff @(posedge clk) begin
    if (!resetn) begin
      r_state <= S_IDLE;
      r_wr    <= 1'b0;
      r_size  <= 2'd0;
      r_addr  <= 32'd0;
      r_wstrb <= 4'd0;
      r_wdata <= 32'd0;
    end else begin
      r_state <= w_state_next;
      if (w_launch) begin
        r_wr    <= es_req_wr;
        r_size  <= norm_size(es_req_size);
        r_addr  <= es_req_addr;
        r_wstrb <= es_req_wr ? mk_wstrb(es_req_size, es_req_addr[1:0]) : 4'd0;
        r_wdata <= mk_wdata(es_req_size, es_req_wdata);
      end
    end
  end

  always_ff @(posedge clk) begin
    if (!resetn) begin
      r_resp_valid <= 1'b0;
      r_resp_rdata <= 32'd0;
    end else begin
      r_resp_valid <= w_fwd;
      if (w_fwd) begin
        r_resp_rdata <= data_sram_rdata;
      end
    end
  end

  assign data_sram_req   = (r_state == S_REQ);
  assign data_sram_wr    = r_wr;
  assign data_sram_size  = r_size;
  assign data_sram_addr  = r_addr;
  assign data_sram_wstrb = r_wstrb;
  assign data_sram_wdata = r_wdata;
  assign ms_resp_valid   = r_resp_valid;
  assign ms_resp_rdata   = r_resp_rdata;

endmodule

// File: tb/tb_data_req_ctrl.sv
// Directed bench for data_req_ctrl; the bus side is driven by hand, cycle by cycle.
module tb_data_req_ctrl;

  logic        clk = 1'b0;
  logic        resetn = 1'b0;
  logic        es_req_valid = 1'b0;
  logic        es_req_wr = 1'b0;
  logic [1:0]  es_req_size = 2'd0;
  logic [31:0] es_req_addr = 32'd0;
  logic [31:0] es_req_wdata = 32'd0;
  logic        es_req_ready;
  logic        flush = 1'b0;
  logic        data_sram_req;
  logic        data_sram_wr;
  logic [1:0]  data_sram_size;
  logic [31:0] data_sram_addr;
  logic [3:0]  data_sram_wstrb;
  logic [31:0] data_sram_wdata;
  logic        data_sram_addr_ok = 1'b0;
  logic        data_sram_data_ok = 1'b0;
  logic [31:0] data_sram_rdata = 32'd0;
  logic        ms_resp_valid;
  logic [31:0] ms_resp_rdata;
  logic        ms_ale;

  int n_cmp = 0;
  int n_bad = 0;

  always #5 clk = ~clk;

  data_req_ctrl #(.OUTSTANDING_MAX(2)) dut (
    .clk(clk), .resetn(resetn),
    .es_req_valid(es_req_valid), .es_req_wr(es_req_wr), .es_req_size(es_req_size),
    .es_req_addr(es_req_addr), .es_req_wdata(es_req_wdata), .es_req_ready(es_req_ready),
    .flush(flush),
    .data_sram_req(data_sram_req), .data_sram_wr(data_sram_wr), .data_sram_size(data_sram_size),
    .data_sram_addr(data_sram_addr), .data_sram_wstrb(data_sram_wstrb), .data_sram_wdata(data_sram_wdata),
    .data_sram_addr_ok(data_sram_addr_ok), .data_sram_data_ok(data_sram_data_ok), .data_sram_rdata(data_sram_rdata),
    .ms_resp_valid(ms_resp_valid), .ms_resp_rdata(ms_resp_rdata), .ms_ale(ms_ale)
  );

  task automatic next_cycle();
    @(posedge clk);
    #1;
  endtask

  task automatic clear_inputs();
    es_req_valid      = 1'b0;
    es_req_wr         = 1'b0;
    es_req_size       = 2'd0;
    es_req_addr       = 32'd0;
    es_req_wdata      = 32'd0;
    flush             = 1'b0;
    data_sram_addr_ok = 1'b0;
    data_sram_data_ok = 1'b0;
    data_sram_rdata   = 32'd0;
  endtask

  task automatic drive_req(input logic wr, input logic [1:0] size, input logic [31:0] addr, input logic [31:0] wdata);
    es_req_valid = 1'b1;
    es_req_wr    = wr;
    es_req_size  = size;
    es_req_addr  = addr;
    es_req_wdata = wdata;
  endtask

  task automatic test_reset();
    resetn = 1'b0;
    clear_inputs();
    es_req_valid = 1'b1;
    next_cycle();
    next_cycle();
    n_cmp++; if (es_req_ready !== 1'b0) begin n_bad++; $display("FAIL rst_ready: got %b expected 0", es_req_ready); end
    n_cmp++; if (data_sram_req !== 1'b0) begin n_bad++; $display("FAIL rst_req: got %b expected 0", data_sram_req); end
    n_cmp++; if (ms_resp_valid !== 1'b0) begin n_bad++; $display("FAIL rst_resp_valid: got %b expected 0", ms_resp_valid); end
    n_cmp++; if (ms_ale !== 1'b0) begin n_bad++; $display("FAIL rst_ale: got %b expected 0", ms_ale); end
    n_cmp++; if (ms_resp_rdata !== 32'd0) begin n_bad++; $display("FAIL rst_rdata: got %h expected 0", ms_resp_rdata); end
    $display("reset: outputs idle");
    resetn = 1'b1;
    es_req_valid = 1'b0;
    next_cycle();
  endtask

  task automatic test_word_load();
    drive_req(1'b0, 2'd2, 32'h0000_1000, 32'd0);
    #1;
    n_cmp++; if (es_req_ready !== 1'b1) begin n_bad++; $display("FAIL wl_ready: got %b expected 1", es_req_ready); end
    next_cycle();
    clear_inputs();
    data_sram_addr_ok = 1'b1;
    #1;
    n_cmp++; if (data_sram_req !== 1'b1) begin n_bad++; $display("FAIL wl_req: got %b expected 1", data_sram_req); end
    n_cmp++; if (data_sram_addr !== 32'h0000_1000) begin n_bad++; $display("FAIL wl_addr: got %h expected 00001000", data_sram_addr); end
    n_cmp++; if (data_sram_wr !== 1'b0) begin n_bad++; $display("FAIL wl_wr: got %b expected 0", data_sram_wr); end
    n_cmp++; if (data_sram_wstrb !== 4'b0000) begin n_bad++; $display("FAIL wl_wstrb: got %b expected 0000", data_sram_wstrb); end
    n_cmp++; if (data_sram_size !== 2'd2) begin n_bad++; $display("FAIL wl_size: got %0d expected 2", data_sram_size); end
    next_cycle();
    clear_inputs();
    #1;
    n_cmp++; if (data_sram_req !== 1'b0) begin n_bad++; $display("FAIL wl_req_drop: got %b expected 0", data_sram_req); end
    next_cycle();
    next_cycle();
    data_sram_data_ok = 1'b1;
    data_sram_rdata   = 32'hDEAD_BEEF;
    #1;
    n_cmp++; if (ms_resp_valid !== 1'b0) begin n_bad++; $display("FAIL wl_resp_early: got %b expected 0", ms_resp_valid); end
    next_cycle();
    clear_inputs();
    #1;
    n_cmp++; if (ms_resp_valid !== 1'b1) begin n_bad++; $display("FAIL wl_resp_valid: got %b expected 1", ms_resp_valid); end
    n_cmp++; if (ms_resp_rdata !== 32'hDEAD_BEEF) begin n_bad++; $display("FAIL wl_resp_rdata: got %h expected deadbeef", ms_resp_rdata); end
    next_cycle();
    n_cmp++; if (ms_resp_valid !== 1'b0) begin n_bad++; $display("FAIL wl_resp_pulse: got %b expected 0", ms_resp_valid); end
    $display("word load 0x00001000 -> rdata %h", 32'hDEAD_BEEF);
  endtask

  task automatic test_store_lanes();
    logic [1:0]  t_size  [3];
    logic [31:0] t_addr  [3];
    logic [31:0] t_wdata [3];
    logic [3:0]  x_wstrb [3];
    logic [31:0] x_wdata [3];
    logic [1:0]  x_size  [3];
    int          t_hold  [3];
    t_size  = '{2'd0, 2'd1, 2'd3};
    t_addr  = '{32'h0000_1003, 32'h0000_1006, 32'h0000_1008};
    t_wdata = '{32'h0000_00AB, 32'h0000_1234, 32'hCAFE_F00D};
    x_wstrb = '{4'b1000, 4'b1100, 4'b1111};
    x_wdata = '{32'hABAB_ABAB, 32'h1234_1234, 32'hCAFE_F00D};
    x_size  = '{2'd0, 2'd1, 2'd2};
    t_hold  = '{3, 0, 1};
    for (int e = 0; e < 3; e++) begin
      drive_req(1'b1, t_size[e], t_addr[e], t_wdata[e]);
      #1;
      next_cycle();
      clear_inputs();
      for (int w = 0; w <= t_hold[e]; w++) begin
        data_sram_addr_ok = (w == t_hold[e]);
        #1;
        n_cmp++; if (data_sram_req !== 1'b1) begin n_bad++; $display("FAIL st%0d_req_w%0d: got %b expected 1", e, w, data_sram_req); end
        n_cmp++; if (data_sram_wr !== 1'b1) begin n_bad++; $display("FAIL st%0d_wr_w%0d: got %b expected 1", e, w, data_sram_wr); end
        n_cmp++; if (data_sram_wstrb !== x_wstrb[e]) begin n_bad++; $display("FAIL st%0d_wstrb_w%0d: got %b expected %b", e, w, data_sram_wstrb, x_wstrb[e]); end
        n_cmp++; if (data_sram_wdata !== x_wdata[e]) begin n_bad++; $display("FAIL st%0d_wdata_w%0d: got %h expected %h", e, w, data_sram_wdata, x_wdata[e]); end
        n_cmp++; if (data_sram_size !== x_size[e]) begin n_bad++; $display("FAIL st%0d_size_w%0d: got %0d expected %0d", e, w, data_sram_size, x_size[e]); end
        n_cmp++; if (data_sram_addr !== t_addr[e]) begin n_bad++; $display("FAIL st%0d_addr_w%0d: got %h expected %h", e, w, data_sram_addr, t_addr[e]); end
        n_cmp++; if (es_req_ready !== (w == t_hold[e])) begin n_bad++; $display("FAIL st%0d_ready_w%0d: got %b expected %b", e, w, es_req_ready, (w == t_hold[e])); end
        next_cycle();
      end
      clear_inputs();
      data_sram_data_ok = 1'b1;
      #1;
      next_cycle();
      clear_inputs();
      #1;
      n_cmp++; if (ms_resp_valid !== 1'b1) begin n_bad++; $display("FAIL st%0d_resp: got %b expected 1", e, ms_resp_valid); end
      $display("store size %0d addr %h -> wstrb %b wdata %h", t_size[e], t_addr[e], x_wstrb[e], x_wdata[e]);
    end
  endtask

  task automatic test_back_to_back();
    drive_req(1'b0, 2'd2, 32'h0000_0100, 32'd0);
    #1;
    n_cmp++; if (es_req_ready !== 1'b1) begin n_bad++; $display("FAIL b2b_ready_a: got %b expected 1", es_req_ready); end
    next_cycle();
    drive_req(1'b0, 2'd2, 32'h0000_0104, 32'd0);
    data_sram_addr_ok = 1'b1;
    #1;
    n_cmp++; if (es_req_ready !== 1'b1) begin n_bad++; $display("FAIL b2b_ready_b: got %b expected 1", es_req_ready); end
    n_cmp++; if (data_sram_addr !== 32'h0000_0100) begin n_bad++; $display("FAIL b2b_addr_a: got %h expected 00000100", data_sram_addr); end
    next_cycle();
    drive_req(1'b0, 2'd2, 32'h0000_0108, 32'd0);
    data_sram_addr_ok = 1'b1;
    #1;
    n_cmp++; if (data_sram_addr !== 32'h0000_0104) begin n_bad++; $display("FAIL b2b_addr_b: got %h expected 00000104", data_sram_addr); end
    n_cmp++; if (es_req_ready !== 1'b0) begin n_bad++; $display("FAIL b2b_stall_issue: got %b expected 0", es_req_ready); end
    next_cycle();
    data_sram_addr_ok = 1'b0;
    for (int c = 0; c < 2; c++) begin
      #1;
      n_cmp++; if (es_req_ready !== 1'b0) begin n_bad++; $display("FAIL b2b_stall_c%0d: got %b expected 0", c, es_req_ready); end
      n_cmp++; if (data_sram_req !== 1'b0) begin n_bad++; $display("FAIL b2b_noreq_c%0d: got %b expected 0", c, data_sram_req); end
      next_cycle();
    end
    data_sram_data_ok = 1'b1;
    data_sram_rdata   = 32'h1111_1111;
    #1;
    n_cmp++; if (es_req_ready !== 1'b1) begin n_bad++; $display("FAIL b2b_ready_after_dok: got %b expected 1", es_req_ready); end
    next_cycle();
    clear_inputs();
    data_sram_addr_ok = 1'b1;
    data_sram_data_ok = 1'b1;
    data_sram_rdata   = 32'h2222_2222;
    #1;
    n_cmp++; if (ms_resp_valid !== 1'b1) begin n_bad++; $display("FAIL b2b_resp1_valid: got %b expected 1", ms_resp_valid); end
    n_cmp++; if (ms_resp_rdata !== 32'h1111_1111) begin n_bad++; $display("FAIL b2b_resp1_rdata: got %h expected 11111111", ms_resp_rdata); end
    n_cmp++; if (data_sram_req !== 1'b1) begin n_bad++; $display("FAIL b2b_req_c: got %b expected 1", data_sram_req); end
    n_cmp++; if (data_sram_addr !== 32'h0000_0108) begin n_bad++; $display("FAIL b2b_addr_c: got %h expected 00000108", data_sram_addr); end
    next_cycle();
    clear_inputs();
    data_sram_data_ok = 1'b1;
    data_sram_rdata   = 32'h3333_3333;
    #1;
    n_cmp++; if (ms_resp_rdata !== 32'h2222_2222) begin n_bad++; $display("FAIL b2b_resp2_rdata: got %h expected 22222222", ms_resp_rdata); end
    next_cycle();
    clear_inputs();
    #1;
    n_cmp++; if (ms_resp_valid !== 1'b1) begin n_bad++; $display("FAIL b2b_resp3_valid: got %b expected 1", ms_resp_valid); end
    n_cmp++; if (ms_resp_rdata !== 32'h3333_3333) begin n_bad++; $display("FAIL b2b_resp3_rdata: got %h expected 33333333", ms_resp_rdata); end
    next_cycle();
    n_cmp++; if (ms_resp_valid !== 1'b0) begin n_bad++; $display("FAIL b2b_resp_end: got %b expected 0", ms_resp_valid); end
    $display("back-to-back loads 0x100/0x104/0x108 -> third stalled until first data_ok");
  endtask

  task automatic test_flush();
    drive_req(1'b0, 2'd2, 32'h0000_0200, 32'd0);
    #1;
    next_cycle();
    drive_req(1'b0, 2'd2, 32'h0000_0204, 32'd0);
    data_sram_addr_ok = 1'b1;
    #1;
    next_cycle();
    clear_inputs();
    data_sram_addr_ok = 1'b1;
    #1;
    next_cycle();
    clear_inputs();
    flush = 1'b1;
    drive_req(1'b0, 2'd2, 32'h0000_0208, 32'd0);
    #1;
    n_cmp++; if (es_req_ready !== 1'b0) begin n_bad++; $display("FAIL fl_ready_blocked: got %b expected 0", es_req_ready); end
    next_cycle();
    flush = 1'b0;
    data_sram_data_ok = 1'b1;
    data_sram_rdata   = 32'hAAAA_0001;
    #1;
    n_cmp++; if (es_req_ready !== 1'b1) begin n_bad++; $display("FAIL fl_ready_after: got %b expected 1", es_req_ready); end
    next_cycle();
    clear_inputs();
    data_sram_data_ok = 1'b1;
    data_sram_rdata   = 32'hAAAA_0002;
    data_sram_addr_ok = 1'b1;
    #1;
    n_cmp++; if (ms_resp_valid !== 1'b0) begin n_bad++; $display("FAIL fl_swallow1: got %b expected 0", ms_resp_valid); end
    n_cmp++; if (data_sram_addr !== 32'h0000_0208) begin n_bad++; $display("FAIL fl_new_addr: got %h expected 00000208", data_sram_addr); end
    next_cycle();
    clear_inputs();
    #1;
    n_cmp++; if (ms_resp_valid !== 1'b0) begin n_bad++; $display("FAIL fl_swallow2: got %b expected 0", ms_resp_valid); end
    data_sram_data_ok = 1'b1;
    data_sram_rdata   = 32'hF00D_F00D;
    next_cycle();
    clear_inputs();
    #1;
    n_cmp++; if (ms_resp_valid !== 1'b1) begin n_bad++; $display("FAIL fl_fwd_valid: got %b expected 1", ms_resp_valid); end
    n_cmp++; if (ms_resp_rdata !== 32'hF00D_F00D) begin n_bad++; $display("FAIL fl_fwd_rdata: got %h expected f00df00d", ms_resp_rdata); end
    $display("flush with two loads in flight -> two swallowed, load 0x208 forwarded");

    // Flush while the request is still waiting for addr_ok.
    drive_req(1'b0, 2'd2, 32'h0000_0300, 32'd0);
    #1;
    next_cycle();
    clear_inputs();
    flush = 1'b1;
    #1;
    n_cmp++; if (data_sram_req !== 1'b1) begin n_bad++; $display("FAIL fl_pend_req: got %b expected 1", data_sram_req); end
    next_cycle();
    clear_inputs();
    #1;
    n_cmp++; if (data_sram_req !== 1'b0) begin n_bad++; $display("FAIL fl_drop: got %b expected 0", data_sram_req); end
    data_sram_data_ok = 1'b1;
    data_sram_rdata   = 32'h0BAD_0BAD;
    next_cycle();
    clear_inputs();
    #1;
    n_cmp++; if (ms_resp_valid !== 1'b0) begin n_bad++; $display("FAIL fl_stray: got %b expected 0", ms_resp_valid); end
    $display("flush of unissued load 0x300 -> dropped, stray data_ok ignored");

    // Flush in the same cycle as addr_ok: the issued load is discarded.
    drive_req(1'b0, 2'd2, 32'h0000_0304, 32'd0);
    #1;
    next_cycle();
    clear_inputs();
    data_sram_addr_ok = 1'b1;
    flush = 1'b1;
    #1;
    next_cycle();
    clear_inputs();
    data_sram_data_ok = 1'b1;
    data_sram_rdata   = 32'h5555_AAAA;
    #1;
    next_cycle();
    clear_inputs();
    #1;
    n_cmp++; if (ms_resp_valid !== 1'b0) begin n_bad++; $display("FAIL fl_addr_ok_discard: got %b expected 0", ms_resp_valid); end
    $display("flush with addr_ok on load 0x304 -> response swallowed");
  endtask

  task automatic test_ale();
    drive_req(1'b0, 2'd1, 32'h0000_2001, 32'd0);
    #1;
    n_cmp++; if (es_req_ready !== 1'b1) begin n_bad++; $display("FAIL ale_ready: got %b expected 1", es_req_ready); end
    next_cycle();
    clear_inputs();
    #1;
`ifdef DATA_REQ_ALE_CHK_EN
    n_cmp++; if (data_sram_req !== 1'b0) begin n_bad++; $display("FAIL ale_noreq: got %b expected 0", data_sram_req); end
    n_cmp++; if (ms_ale !== 1'b1) begin n_bad++; $display("FAIL ale_pulse: got %b expected 1", ms_ale); end
    n_cmp++; if (ms_resp_valid !== 1'b0) begin n_bad++; $display("FAIL ale_noresp: got %b expected 0", ms_resp_valid); end
    next_cycle();
    n_cmp++; if (ms_ale !== 1'b0) begin n_bad++; $display("FAIL ale_pulse_end: got %b expected 0", ms_ale); end
    $display("half load 0x2001 -> ms_ale, no bus request");
`else
    n_cmp++; if (data_sram_req !== 1'b1) begin n_bad++; $display("FAIL ale_req: got %b expected 1", data_sram_req); end
    n_cmp++; if (data_sram_size !== 2'd1) begin n_bad++; $display("FAIL ale_size: got %0d expected 1", data_sram_size); end
    n_cmp++; if (data_sram_addr !== 32'h0000_2001) begin n_bad++; $display("FAIL ale_addr: got %h expected 00002001", data_sram_addr); end
    n_cmp++; if (ms_ale !== 1'b0) begin n_bad++; $display("FAIL ale_tied: got %b expected 0", ms_ale); end
    data_sram_addr_ok = 1'b1;
    next_cycle();
    clear_inputs();
    data_sram_data_ok = 1'b1;
    data_sram_rdata   = 32'h0000_0077;
    next_cycle();
    clear_inputs();
    #1;
    n_cmp++; if (ms_resp_valid !== 1'b1) begin n_bad++; $display("FAIL ale_resp: got %b expected 1", ms_resp_valid); end
    $display("half load 0x2001 -> issued on bus unchanged");
`endif
  endtask

  task automatic test_reset_mid();
    drive_req(1'b0, 2'd2, 32'h0000_0400, 32'd0);
    #1;
    next_cycle();
    drive_req(1'b1, 2'd0, 32'h0000_0401, 32'h0000_00CD);
    data_sram_addr_ok = 1'b1;
    #1;
    next_cycle();
    clear_inputs();
    #1;
    n_cmp++; if (data_sram_req !== 1'b1) begin n_bad++; $display("FAIL rm_in_req: got %b expected 1", data_sram_req); end
    n_cmp++; if (data_sram_wstrb !== 4'b0010) begin n_bad++; $display("FAIL rm_wstrb: got %b expected 0010", data_sram_wstrb); end
    resetn = 1'b0;
    drive_req(1'b0, 2'd2, 32'h0000_0500, 32'd0);
    #1;
    n_cmp++; if (es_req_ready !== 1'b0) begin n_bad++; $display("FAIL rm_ready: got %b expected 0", es_req_ready); end
    next_cycle();
    clear_inputs();
    #1;
    n_cmp++; if (data_sram_req !== 1'b0) begin n_bad++; $display("FAIL rm_req: got %b expected 0", data_sram_req); end
    n_cmp++; if (data_sram_wstrb !== 4'd0) begin n_bad++; $display("FAIL rm_wstrb_clr: got %b expected 0000", data_sram_wstrb); end
    n_cmp++; if (data_sram_wdata !== 32'd0) begin n_bad++; $display("FAIL rm_wdata: got %h expected 0", data_sram_wdata); end
    n_cmp++; if (data_sram_addr !== 32'd0) begin n_bad++; $display("FAIL rm_addr: got %h expected 0", data_sram_addr); end
    n_cmp++; if (ms_resp_valid !== 1'b0) begin n_bad++; $display("FAIL rm_resp_valid: got %b expected 0", ms_resp_valid); end
    n_cmp++; if (ms_resp_rdata !== 32'd0) begin n_bad++; $display("FAIL rm_resp_rdata: got %h expected 0", ms_resp_rdata); end
    n_cmp++; if (ms_ale !== 1'b0) begin n_bad++; $display("FAIL rm_ale: got %b expected 0", ms_ale); end
    resetn = 1'b1;
    next_cycle();
    data_sram_data_ok = 1'b1;
    data_sram_rdata   = 32'h0000_0099;
    next_cycle();
    clear_inputs();
    #1;
    n_cmp++; if (ms_resp_valid !== 1'b0) begin n_bad++; $display("FAIL rm_stray: got %b expected 0", ms_resp_valid); end
    $display("reset during store 0x401 -> abandoned, stray data_ok ignored");
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "bench did not complete");
  end

  initial begin
    clear_inputs();
    test_reset();
    test_word_load();
    test_store_lanes();
    test_back_to_back();
    test_flush();
    test_ale();
    test_reset_mid();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
